// File: rtl/vram_request_responder.sv
// ============================================================================
// Module      : vram_request_responder
// Description : Serves the renderer's VRAM read/write request ports and drives
//               the external asynchronous SRAM holding the frame buffers.
//               Word addresses are 20 bits; data words are 24-bit pixel tuples
//               (two RGB444 pixels). Reads return data with a one-cycle valid
//               pulse, and each committed write returns a one-cycle done pulse.
//               The pin-level tristate buffer lives in the top level.
// Ports       :
//   i_master_clk / i_reset_n          clock, async active-low reset
//   i_vram_read_address/_request      read request port (pulse)
//   o_vram_read_data/_valid           read result, valid is a 1-cycle pulse
//   i_vram_write_address/_data/_request  write request port (pulse)
//   o_vram_write_done                 1-cycle pulse, write committed
//   o_sram_address/_data_out/_data_oe SRAM address, write data, bus drive enable
//   i_sram_data_in                    SRAM data bus input
//   o_sram_ce_n/_oe_n/_we_n           SRAM strobes, active low
//   o_busy                            high whenever an access is in progress
//   o_overflow                        sticky, a request was dropped
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_request_responder #(
  parameter int READ_WAIT_CYCLES  = 2,
  parameter int WRITE_WAIT_CYCLES = 2
) (
  input  logic        i_master_clk,
  input  logic        i_reset_n,
  input  logic [19:0] i_vram_read_address,
  input  logic        i_vram_read_request,
  output logic [23:0] o_vram_read_data,
  output logic        o_vram_read_data_valid,
  input  logic [19:0] i_vram_write_address,
  input  logic [23:0] i_vram_write_data,
  input  logic        i_vram_write_request,
  output logic        o_vram_write_done,
  output logic [19:0] o_sram_address,
  output logic [23:0] o_sram_data_out,
  output logic        o_sram_data_oe,
  input  logic [23:0] i_sram_data_in,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_busy,
  output logic        o_overflow
);

  localparam int C_MAX_WAIT = (READ_WAIT_CYCLES > WRITE_WAIT_CYCLES) ?
                              READ_WAIT_CYCLES : WRITE_WAIT_CYCLES;
  localparam int C_CW       = $clog2(C_MAX_WAIT) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACCESS = 3'd1,
    WR_SETUP  = 3'd2,
    WR_PULSE  = 3'd3,
    WR_HOLD   = 3'd4
  } state_t;

  state_t            r_state;
  logic [C_CW-1:0]   r_wait_cnt;
  logic              r_rd_pend;
  logic [19:0]       r_rd_slot_addr;
  logic              r_wr_pend;
  logic [19:0]       r_wr_slot_addr;
  logic [23:0]       r_wr_slot_data;

  // A pending slot takes priority over a live pulse on the same port, so the
  // older request is always served first.
  logic              w_eff_rd;
  logic              w_eff_wr;
  logic [19:0]       w_sel_rd_addr;
  logic [19:0]       w_sel_wr_addr;
  logic [23:0]       w_sel_wr_data;

  assign w_eff_rd      = r_rd_pend | i_vram_read_request;
  assign w_eff_wr      = r_wr_pend | i_vram_write_request;
  assign w_sel_rd_addr = r_rd_pend ? r_rd_slot_addr : i_vram_read_address;
  assign w_sel_wr_addr = r_wr_pend ? r_wr_slot_addr : i_vram_write_address;
  assign w_sel_wr_data = r_wr_pend ? r_wr_slot_data : i_vram_write_data;

  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state                <= IDLE;
      r_wait_cnt             <= '0;
      r_rd_pend              <= 1'b0;
      r_rd_slot_addr         <= '0;
      r_wr_pend              <= 1'b0;
      r_wr_slot_addr         <= '0;
      r_wr_slot_data         <= '0;
      o_vram_read_data       <= '0;
      o_vram_read_data_valid <= 1'b0;
      o_vram_write_done      <= 1'b0;
      o_sram_address         <= '0;
      o_sram_data_out        <= '0;
      o_sram_data_oe         <= 1'b0;
      o_sram_ce_n            <= 1'b1;
      o_sram_oe_n            <= 1'b1;
      o_sram_we_n            <= 1'b1;
      o_busy                 <= 1'b0;
      o_overflow             <= 1'b0;
    end else begin
      o_vram_read_data_valid <= 1'b0;
      o_vram_write_done      <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_eff_rd) begin
            r_state        <= RD_ACCESS;
            o_busy         <= 1'b1;
            o_sram_address <= w_sel_rd_addr;
            o_sram_ce_n    <= 1'b0;
            o_sram_oe_n    <= 1'b0;
            r_wait_cnt     <= C_CW'(READ_WAIT_CYCLES);
            r_rd_pend      <= 1'b0;
            // Pending read consumed while a new pulse arrives: the slot was
            // full when the pulse showed up, so the pulse is dropped.
            if (r_rd_pend && i_vram_read_request) begin
              o_overflow <= 1'b1;
            end
            // The losing write parks in its slot.
            if (i_vram_write_request) begin
              if (r_wr_pend) begin
                o_overflow <= 1'b1;
              end else begin
                r_wr_pend      <= 1'b1;
                r_wr_slot_addr <= i_vram_write_address;
                r_wr_slot_data <= i_vram_write_data;
              end
            end
          end else if (w_eff_wr) begin
            r_state         <= WR_SETUP;
            o_busy          <= 1'b1;
            o_sram_address  <= w_sel_wr_addr;
            o_sram_data_out <= w_sel_wr_data;
            o_sram_ce_n     <= 1'b0;
            o_sram_data_oe  <= 1'b1;
            o_sram_we_n     <= 1'b1;
            r_wait_cnt      <= C_CW'(WRITE_WAIT_CYCLES);
            r_wr_pend       <= 1'b0;
            if (r_wr_pend && i_vram_write_request) begin
              o_overflow <= 1'b1;
            end
          end
        end

        RD_ACCESS: begin
          if (r_wait_cnt == C_CW'(1)) begin
            o_vram_read_data       <= i_sram_data_in;
            o_vram_read_data_valid <= 1'b1;
            o_sram_ce_n            <= 1'b1;
            o_sram_oe_n            <= 1'b1;
            o_busy                 <= 1'b0;
            r_state                <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt - C_CW'(1);
          end
        end

        WR_SETUP: begin
          o_sram_we_n <= 1'b0;
          r_state     <= WR_PULSE;
        end

        WR_PULSE: begin
          if (r_wait_cnt == C_CW'(1)) begin
            // Rising WE_n commits the word; address and data stay put for
            // one more cycle of hold time.
            o_sram_we_n <= 1'b1;
            r_state     <= WR_HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt - C_CW'(1);
          end
        end

        WR_HOLD: begin
          o_sram_data_oe    <= 1'b0;
          o_sram_ce_n       <= 1'b1;
          o_vram_write_done <= 1'b1;
          o_busy            <= 1'b0;
          r_state           <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase

      // Requests arriving during an access wait in their slot.
      if (r_state != IDLE) begin
        if (i_vram_read_request) begin
          if (r_rd_pend) begin
            o_overflow <= 1'b1;
          end else begin
            r_rd_pend      <= 1'b1;
            r_rd_slot_addr <= i_vram_read_address;
          end
        end
        if (i_vram_write_request) begin
          if (r_wr_pend) begin
            o_overflow <= 1'b1;
          end else begin
            r_wr_pend      <= 1'b1;
            r_wr_slot_addr <= i_vram_write_address;
            r_wr_slot_data <= i_vram_write_data;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_request_responder.sv
// ============================================================================
// Module      : tb_vram_request_responder
// Description : Self-checking bench for vram_request_responder with a
//               behavioural asynchronous SRAM and a read/write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_request_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] rd_addr = '0;
  logic        rd_req = 1'b0;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic [19:0] wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        wr_req = 1'b0;
  logic        wr_done;
  logic [19:0] s_addr;
  logic [23:0] s_dout;
  logic        s_doe;
  logic [23:0] s_din;
  logic        s_ce_n, s_oe_n, s_we_n;
  logic        busy, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] a;
    logic [23:0] d;
  } wr_t;

  logic [23:0] rd_q[$];
  wr_t         wr_q[$];
  logic [23:0] sram_mem [logic [19:0]];
  logic [23:0] ref_mem  [logic [19:0]];

  always #5 clk = ~clk;

  vram_request_responder #(
    .READ_WAIT_CYCLES (2),
    .WRITE_WAIT_CYCLES(2)
  ) dut (
    .i_master_clk          (clk),
    .i_reset_n             (rst_n),
    .i_vram_read_address   (rd_addr),
    .i_vram_read_request   (rd_req),
    .o_vram_read_data      (rd_data),
    .o_vram_read_data_valid(rd_valid),
    .i_vram_write_address  (wr_addr),
    .i_vram_write_data     (wr_data),
    .i_vram_write_request  (wr_req),
    .o_vram_write_done     (wr_done),
    .o_sram_address        (s_addr),
    .o_sram_data_out       (s_dout),
    .o_sram_data_oe        (s_doe),
    .i_sram_data_in        (s_din),
    .o_sram_ce_n           (s_ce_n),
    .o_sram_oe_n           (s_oe_n),
    .o_sram_we_n           (s_we_n),
    .o_busy                (busy),
    .o_overflow            (overflow)
  );

  // Behavioural asynchronous SRAM: combinational read, write on rising WE_n.
  function automatic logic [23:0] sram_read(input logic [19:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : 24'h000000;
  endfunction

  assign s_din = (!s_ce_n && !s_oe_n) ? sram_read(s_addr) : 24'h000000;

  always @(posedge s_we_n) begin
    if (s_ce_n === 1'b0) sram_mem[s_addr] = s_dout;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({s_ce_n, s_oe_n, s_we_n} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b want 111", {s_ce_n, s_oe_n, s_we_n}); end
    checks++; if (s_doe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", s_doe); end
    checks++; if (s_addr !== 20'h0 || s_dout !== 24'h0) begin errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", s_addr, s_dout); end
    checks++; if (rd_data !== 24'h0) begin errors++; $display("FAIL reset_read_data: got %h want 0", rd_data); end
    checks++; if ({rd_valid, wr_done, busy, overflow} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {rd_valid, wr_done, busy, overflow}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [23:0] exp;
    logic        e_valid;
    sram_mem[20'h12345] = 24'hABCDEF;
    ref_mem[20'h12345]  = 24'hABCDEF;
    @(negedge clk);
    rd_addr = 20'h12345; rd_req = 1'b1;
    rd_q.push_back(ref_mem[20'h12345]);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      rd_req = 1'b0;
      e_valid = (c == 3);
      checks++; if (s_oe_n !== ((c == 1 || c == 2) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL rd_oe_n cycle %0d: got %b", c, s_oe_n); end
      checks++; if (rd_valid !== e_valid) begin errors++; $display("FAIL rd_valid cycle %0d: got %b want %b", c, rd_valid, e_valid); end
      if (rd_valid === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin errors++; $display("FAIL rd_unexpected_valid: got valid want none"); end
        else begin exp = rd_q.pop_front(); if (rd_data !== exp) begin errors++; $display("FAIL rd_data: got %h want %h", rd_data, exp); end end
      end
    end
    checks++; if (rd_data !== 24'hABCDEF) begin errors++; $display("FAIL rd_data_stable: got %h want abcdef", rd_data); end
  endtask

  task automatic test_single_write();
    wr_t w;
    logic e_we_n, e_doe, e_done;
    @(negedge clk);
    wr_addr = 20'h00010; wr_data = 24'h0F0F0F; wr_req = 1'b1;
    ref_mem[20'h00010] = 24'h0F0F0F;
    wr_q.push_back('{a: 20'h00010, d: 24'h0F0F0F});
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      wr_req = 1'b0;
      e_we_n = !(c == 2 || c == 3);
      e_doe  = (c >= 1 && c <= 4);
      e_done = (c == 5);
      checks++; if (s_we_n !== e_we_n) begin errors++; $display("FAIL wr_we_n cycle %0d: got %b want %b", c, s_we_n, e_we_n); end
      checks++; if (s_doe !== e_doe) begin errors++; $display("FAIL wr_data_oe cycle %0d: got %b want %b", c, s_doe, e_doe); end
      checks++; if (wr_done !== e_done) begin errors++; $display("FAIL wr_done cycle %0d: got %b want %b", c, wr_done, e_done); end
      if (wr_done === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin errors++; $display("FAIL wr_unexpected_done: got done want none"); end
        else begin
          w = wr_q.pop_front();
          if (sram_read(w.a) !== w.d) begin errors++; $display("FAIL wr_commit @%h: got %h want %h", w.a, sram_read(w.a), w.d); end
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [23:0] exp;
    wr_t  w;
    logic e_valid, e_done;
    sram_mem[20'h00200] = 24'h123456;
    ref_mem[20'h00200]  = 24'h123456;
    @(negedge clk);
    rd_addr = 20'h00200; rd_req = 1'b1;
    wr_addr = 20'h00300; wr_data = 24'h654321; wr_req = 1'b1;
    rd_q.push_back(ref_mem[20'h00200]);
    ref_mem[20'h00300] = 24'h654321;
    wr_q.push_back('{a: 20'h00300, d: 24'h654321});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      e_valid = (c == 3);
      e_done  = (c == 8);
      checks++; if (rd_valid !== e_valid) begin errors++; $display("FAIL sim_valid cycle %0d: got %b want %b", c, rd_valid, e_valid); end
      checks++; if (wr_done !== e_done) begin errors++; $display("FAIL sim_done cycle %0d: got %b want %b", c, wr_done, e_done); end
      checks++; if (s_oe_n === 1'b0 && s_doe === 1'b1) begin errors++; $display("FAIL sim_bus_conflict cycle %0d: got oe_n=0 data_oe=1 want exclusive", c); end
      if (c == 4) begin
        checks++; if ({s_ce_n, s_doe, s_we_n, busy} !== 4'b0111) begin errors++; $display("FAIL sim_wr_setup: got ce_n/doe/we_n/busy=%b want 0111", {s_ce_n, s_doe, s_we_n, busy}); end
      end
      if (rd_valid === 1'b1 && rd_q.size() != 0) begin
        exp = rd_q.pop_front();
        checks++; if (rd_data !== exp) begin errors++; $display("FAIL sim_rd_data: got %h want %h", rd_data, exp); end
      end
      if (wr_done === 1'b1 && wr_q.size() != 0) begin
        w = wr_q.pop_front();
        checks++; if (sram_read(w.a) !== w.d) begin errors++; $display("FAIL sim_wr_commit @%h: got %h want %h", w.a, sram_read(w.a), w.d); end
      end
    end
  endtask

  task automatic test_rmw();
    logic [19:0] a;
    logic [23:0] exp, nv;
    wr_t w;
    bit  got;
    for (int i = 0; i < 4; i++) begin
      a = 20'h01000 + 20'(i * 3);
      sram_mem[a] = 24'h100000 * 24'(i + 1) + 24'h000ABC;
      ref_mem[a]  = 24'h100000 * 24'(i + 1) + 24'h000ABC;
    end
    for (int i = 0; i < 4; i++) begin
      a = 20'h01000 + 20'(i * 3);
      @(negedge clk);
      rd_addr = a; rd_req = 1'b1;
      rd_q.push_back(ref_mem[a]);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        rd_req = 1'b0;
        if (rd_valid === 1'b1) begin
          got = 1'b1;
          exp = rd_q.pop_front();
          checks++; if (rd_data !== exp) begin errors++; $display("FAIL rmw_rd_data[%0d]: got %h want %h", i, rd_data, exp); end
          // Modify the pixel tuple and write it back in the valid cycle.
          nv = exp ^ 24'h5A5A5A;
          wr_addr = a; wr_data = nv; wr_req = 1'b1;
          ref_mem[a] = nv;
          wr_q.push_back('{a: a, d: nv});
        end
      end
      if (!got) begin checks++; errors++; $display("FAIL rmw_rd_timeout[%0d]: got no valid want valid", i); rd_q.delete(); end
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        wr_req = 1'b0;
        if (wr_done === 1'b1 && wr_q.size() != 0) begin
          got = 1'b1;
          w = wr_q.pop_front();
          checks++; if (sram_read(w.a) !== w.d) begin errors++; $display("FAIL rmw_wr_commit[%0d]: got %h want %h", i, sram_read(w.a), w.d); end
        end
      end
      wr_req = 1'b0;
      if (!got) begin checks++; errors++; $display("FAIL rmw_wr_timeout[%0d]: got no done want done", i); wr_q.delete(); end
    end
    for (int i = 0; i < 4; i++) begin
      a = 20'h01000 + 20'(i * 3);
      checks++; if (sram_read(a) !== ref_mem[a]) begin errors++; $display("FAIL rmw_mem[%0d]: got %h want %h", i, sram_read(a), ref_mem[a]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmw_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [23:0] exp;
    int   nvalid = 0;
    bit   got;
    for (int i = 0; i < 3; i++) begin
      sram_mem[20'h02000 + 20'(i)] = 24'h111111 * 24'(i + 1);
      ref_mem[20'h02000 + 20'(i)]  = 24'h111111 * 24'(i + 1);
    end
    rd_q.push_back(ref_mem[20'h02000]);
    rd_q.push_back(ref_mem[20'h02001]);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c >= 1 && rd_valid === 1'b1) begin
        nvalid++;
        if (rd_q.size() != 0) begin
          exp = rd_q.pop_front();
          checks++; if (rd_data !== exp) begin errors++; $display("FAIL ovf_rd_data: got %h want %h", rd_data, exp); end
        end
      end
      rd_req  = (c <= 2);
      rd_addr = 20'h02000 + 20'(c);
    end
    rd_req = 1'b0;
    checks++; if (nvalid != 2) begin errors++; $display("FAIL ovf_valid_count: got %0d want 2", nvalid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    // Later traffic must leave the sticky flag alone.
    @(negedge clk);
    wr_addr = 20'h02005; wr_data = 24'hC0FFEE; wr_req = 1'b1;
    ref_mem[20'h02005] = 24'hC0FFEE;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      wr_req = 1'b0;
      if (wr_done === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL ovf_wr_timeout: got no done want done"); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    wr_addr = 20'h03000; wr_data = 24'h777777; wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    checks++; if (s_we_n !== 1'b0) begin errors++; $display("FAIL rst_mid_in_pulse: got we_n=%b want 0", s_we_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s_we_n !== 1'b1 || s_doe !== 1'b0) begin errors++; $display("FAIL rst_mid_immediate: got we_n=%b doe=%b want 1/0", s_we_n, s_doe); end
    checks++; if (s_ce_n !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got ce_n=%b busy=%b ovf=%b want 1/0/0", s_ce_n, busy, overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (wr_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_after cycle %0d: got done=%b busy=%b want 0/0", c, wr_done, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_simultaneous();
    test_rmw();
    test_overflow();
    test_reset_mid_write();
    checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d/%0d entries want 0/0", rd_q.size(), wr_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
